// File: rtl/pov_column_shifter.sv
// -----------------------------------------------------------------------------
// pov_column_shifter
//
// Downstream stage of the POV transmitter controller. While SendData is high,
// the glyph captured in IDLE is serialised one column at a time, MSB first,
// into an external LED shift/storage register pair (SER/SRCLK/RCLK style).
// Each column is strobed into the storage register with a one-cycle Latch
// pulse and then held for HOLD_CYCLES clocks. After the last column, CharDone
// is raised and held until the controller drops SendData.
//
// Optional build macro:
//   POV_GAP_COLUMN_EN - when defined, one extra all-zero column is shifted,
//                       latched and held after the last glyph column. It uses
//                       the same timing as a glyph column and gives spacing
//                       between characters; CharDone comes one column period
//                       later. When undefined, DONE follows the last glyph
//                       column directly.
//
// Parameters:
//   LEDS        - LEDs per column (bits shifted per column)
//   COLS        - columns per glyph
//   DIV         - SerClk half-period in clk cycles (>= 1)
//   HOLD_CYCLES - column dwell time in clk cycles after the latch (>= 1)
//
// Ports:
//   clk      in   system clock, rising edge
//   Reset    in   synchronous, active-high reset
//   SendData in   level request; high = emit the captured glyph, low = abort
//                 or acknowledge DONE
//   Glyph    in   LEDS*COLS column patterns; column c = Glyph[c*LEDS +: LEDS]
//   SerData  out  serial data to the LED shift register
//   SerClk   out  shift clock; SerData is valid on its rising edge
//   Latch    out  one-cycle storage-register strobe
//   Busy     out  high while shifting, latching or holding
//   CharDone out  high in DONE (drives the controller's NullDataChar)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module pov_column_shifter #(
    parameter int LEDS        = 8,
    parameter int COLS        = 5,
    parameter int DIV         = 2,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   SendData,
    input  logic [LEDS*COLS-1:0]   Glyph,
    output logic                   SerData,
    output logic                   SerClk,
    output logic                   Latch,
    output logic                   Busy,
    output logic                   CharDone
);

`ifdef POV_GAP_COLUMN_EN
    localparam int NCOL = COLS + 1;
`else
    localparam int NCOL = COLS;
`endif

    localparam int COL_W  = (NCOL > 1)        ? $clog2(NCOL)        : 1;
    localparam int BIT_W  = (LEDS > 1)        ? $clog2(LEDS)        : 1;
    localparam int DIV_W  = (DIV > 1)         ? $clog2(DIV)         : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NCOL - 1);
    localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(LEDS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state_reg;
    logic [LEDS*COLS-1:0]  glyph_reg;
    logic [COL_W-1:0]      col_reg;
    logic [BIT_W-1:0]      bit_reg;
    logic [DIV_W-1:0]      div_reg;
    logic [HOLD_W-1:0]     hold_reg;

    // Column view of the captured glyph. Any column index at or beyond COLS
    // (only the optional gap column) reads as all zeros.
    logic [LEDS-1:0] col_words [NCOL];

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_col
            if (gi < COLS) begin : g_glyph
                assign col_words[gi] = glyph_reg[gi*LEDS +: LEDS];
            end else begin : g_gap
                assign col_words[gi] = '0;
            end
        end
    endgenerate

    logic [COL_W-1:0] col_next;
    logic [BIT_W-1:0] bit_next;
    logic [LEDS-1:0]  cur_word;
    logic [LEDS-1:0]  next_word;

    always_comb begin
        col_next  = col_reg + 1'b1;
        bit_next  = bit_reg - 1'b1;
        cur_word  = col_words[col_reg];
        // Only meaningful when another column follows; guarded so the index
        // never leaves the array on the terminal column.
        next_word = (col_reg != COL_LAST) ? col_words[col_next] : '0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            glyph_reg <= '0;
            col_reg   <= '0;
            bit_reg   <= '0;
            div_reg   <= '0;
            hold_reg  <= '0;
            SerData   <= 1'b0;
            SerClk    <= 1'b0;
            Latch     <= 1'b0;
            Busy      <= 1'b0;
            CharDone  <= 1'b0;
        end else begin
            // Latch is a strobe: it is only ever set for the single cycle
            // spent in LATCH.
            Latch <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (SendData) begin
                        glyph_reg <= Glyph;
                        col_reg   <= '0;
                        bit_reg   <= BIT_MSB;
                        div_reg   <= '0;
                        hold_reg  <= '0;
                        // Present the MSB of column 0 straight away so the
                        // first low phase already carries valid data.
                        SerData   <= Glyph[LEDS-1];
                        SerClk    <= 1'b0;
                        Busy      <= 1'b1;
                        state_reg <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!SendData) begin
                        // Abort: the partial column is dropped unlatched.
                        state_reg <= S_IDLE;
                        SerData   <= 1'b0;
                        SerClk    <= 1'b0;
                        Busy      <= 1'b0;
                        div_reg   <= '0;
                    end else if (div_reg != DIV_LAST) begin
                        div_reg <= div_reg + 1'b1;
                    end else begin
                        div_reg <= '0;
                        if (!SerClk) begin
                            SerClk <= 1'b1;
                        end else if (bit_reg != '0) begin
                            bit_reg <= bit_next;
                            SerClk  <= 1'b0;
                            SerData <= cur_word[bit_next];
                        end else begin
                            SerClk    <= 1'b0;
                            SerData   <= 1'b0;
                            Latch     <= 1'b1;
                            state_reg <= S_LATCH;
                        end
                    end
                end

                S_LATCH: begin
                    if (!SendData) begin
                        state_reg <= S_IDLE;
                        Busy      <= 1'b0;
                    end else begin
                        hold_reg  <= '0;
                        state_reg <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (!SendData) begin
                        state_reg <= S_IDLE;
                        Busy      <= 1'b0;
                        hold_reg  <= '0;
                    end else if (hold_reg != HOLD_LAST) begin
                        hold_reg <= hold_reg + 1'b1;
                    end else if (col_reg != COL_LAST) begin
                        col_reg   <= col_next;
                        bit_reg   <= BIT_MSB;
                        div_reg   <= '0;
                        hold_reg  <= '0;
                        SerData   <= next_word[LEDS-1];
                        state_reg <= S_SHIFT;
                    end else begin
                        hold_reg  <= '0;
                        Busy      <= 1'b0;
                        CharDone  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!SendData) begin
                        CharDone  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    SerClk    <= 1'b0;
                    Busy      <= 1'b0;
                    CharDone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pov_column_shifter.sv
// -----------------------------------------------------------------------------
// tb_pov_column_shifter
//
// Self-checking bench for pov_column_shifter with LEDS=8, COLS=5, DIV=1,
// HOLD_CYCLES=4 (21 cycles per column). A behavioural model tracks the run as
// "cycles since capture" and derives every output from that count; it is
// compared with the DUT on every cycle. Directed scenarios (bit order, full
// character, handshake, abort, mid-run reset) add literal expectations, then
// a randomized phase exercises SendData/Reset/Glyph freely.
// Honours POV_GAP_COLUMN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pov_column_shifter;

    localparam int LEDS  = 8;
    localparam int COLS  = 5;
    localparam int DIV   = 1;
    localparam int HOLD  = 4;
    localparam int GW    = LEDS * COLS;
    localparam int SHIFT_LEN = 2 * DIV * LEDS;
    localparam int PER   = SHIFT_LEN + 1 + HOLD;
`ifdef POV_GAP_COLUMN_EN
    localparam int NCOL = COLS + 1;
    localparam int DONE_LIT = 126;
`else
    localparam int NCOL = COLS;
    localparam int DONE_LIT = 105;
`endif

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          SendData = 1'b0;
    logic [GW-1:0] Glyph = '0;
    logic          SerData, SerClk, Latch, Busy, CharDone;

    pov_column_shifter #(
        .LEDS(LEDS), .COLS(COLS), .DIV(DIV), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .Reset(Reset), .SendData(SendData), .Glyph(Glyph),
        .SerData(SerData), .SerClk(SerClk), .Latch(Latch),
        .Busy(Busy), .CharDone(CharDone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 = idle, 1 = running (m_t cycles since capture), 2 = done
    int            m_mode = 0;
    int            m_t = 0;
    int            cap_cyc = 0;
    bit            m_valid = 0;
    logic [GW-1:0] m_glyph = '0;

    always @(posedge clk) begin
        cyc++;
        if (Reset) begin
            m_mode  = 0;
            m_valid = 1;
        end else begin
            case (m_mode)
                0: if (SendData) begin
                       m_mode = 1; m_t = 0; m_glyph = Glyph; cap_cyc = cyc;
                   end
                1: if (!SendData) m_mode = 0;
                   else begin
                       m_t++;
                       if (m_t == NCOL * PER) m_mode = 2;
                   end
                default: if (!SendData) m_mode = 0;
            endcase
        end
    end

    // One compare process against the model, every cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [3:0] e_vec;
            logic       e_data;
            bit         data_valid;
            int         c, r, b;
            e_vec = 4'b0000;   // {SerClk, Latch, Busy, CharDone}
            e_data = 1'b0;
            data_valid = 0;
            if (m_mode == 1) begin
                c = m_t / PER;
                r = m_t % PER;
                e_vec[1] = 1'b1;
                if (r < SHIFT_LEN) begin
                    b = LEDS - 1 - r / (2 * DIV);
                    e_vec[3] = ((r % (2 * DIV)) >= DIV);
                    e_data = (c < COLS) ? m_glyph[c*LEDS + b] : 1'b0;
                    data_valid = 1;
                end else if (r == SHIFT_LEN) begin
                    e_vec[2] = 1'b1;
                end
            end else if (m_mode == 2) begin
                e_vec[0] = 1'b1;
            end
            chk("model_outputs", {60'd0, SerClk, Latch, Busy, CharDone}, {60'd0, e_vec});
            if (data_valid) chk("model_serdata", {63'd0, SerData}, {63'd0, e_data});
        end
    end

    // ---------------- event monitor ----------------
    bit   rises[$];
    int   latches[$];
    int   done_cyc = -1;
    logic prev_clk = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (SerClk === 1'b1 && prev_clk === 1'b0) rises.push_back(SerData);
        if (Latch === 1'b1) latches.push_back(cyc);
        if (CharDone === 1'b1 && prev_done === 1'b0) done_cyc = cyc;
        prev_clk  = SerClk;
        prev_done = CharDone;
    end

    // Stimulus acts just after the falling edge, after monitor/compare.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_model(input int mode, input int t, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_mode == mode && (t < 0 || m_t == t)) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout after %0d cycles, model mode %0d required %0d", name, n, m_mode, mode);
        end
    endtask

    function automatic logic [7:0] first_byte();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], (i < rises.size()) ? rises[i] : 1'bx};
        return v;
    endfunction

    initial begin
        logic [GW-1:0] g2;
        int n0, l0, spacing_bad;

        // ---- reset ----
        repeat (3) step();
        chk("reset_outputs", {59'd0, SerData, SerClk, Latch, Busy, CharDone}, 64'd0);
        Reset = 1'b0;
        step();

        // ---- bit order + full character ----
        Glyph = '0;
        Glyph[7:0] = 8'hA5;
        rises.delete(); latches.delete(); done_cyc = -1;
        SendData = 1'b1;
        wait_model(2, -1, 400, "full_char_wait");
        step();
        chk("bit_order_A5", {56'd0, first_byte()}, {56'd0, 8'hA5});
        chk("rise_count", rises.size(), 8 * NCOL);
        chk("latch_count", latches.size(), NCOL);
        if (latches.size() > 0) chk("first_latch_offset", latches[0] - cap_cyc, 2 * DIV * LEDS);
        spacing_bad = 0;
        for (int i = 1; i < latches.size(); i++)
            if (latches[i] - latches[i-1] != 21) spacing_bad++;
        chk("latch_spacing", spacing_bad, 0);
        chk("chardone_offset", done_cyc - cap_cyc, DONE_LIT);
`ifdef POV_GAP_COLUMN_EN
        if (rises.size() >= 48) begin
            logic [7:0] gap;
            for (int i = 40; i < 48; i++) gap = {gap[6:0], rises[i]};
            chk("gap_column_zero", {56'd0, gap}, 64'd0);
        end
`endif
        $display("scenario full_char: capture=%0d done=%0d latches=%0d", cap_cyc, done_cyc, latches.size());

        // ---- handshake ----
        for (int i = 0; i < 10; i++) begin
            chk("done_held", {63'd0, CharDone}, 64'd1);
            step();
        end
        SendData = 1'b0;
        step();
        chk("done_drop", {62'd0, CharDone, Busy}, 64'd0);
        $display("scenario handshake: CharDone released");

        // ---- abort during column 2 bit 4 ----
        Glyph = GW'({$urandom(), $urandom()});
        SendData = 1'b1;
        wait_model(1, 2 * PER + (LEDS - 1 - 4) * 2 * DIV, 200, "abort_wait");
        SendData = 1'b0;
        step();
        chk("abort_idle", {61'd0, SerClk, Latch, Busy}, 64'd0);
        n0 = rises.size();
        l0 = latches.size();
        repeat (5) step();
        chk("abort_no_serclk", rises.size(), n0);
        chk("abort_no_latch", latches.size(), l0);
        g2 = GW'({$urandom(), $urandom()});
        Glyph = g2;
        rises.delete();
        SendData = 1'b1;
        repeat (18) step();
        chk("restart_col0", {56'd0, first_byte()}, {56'd0, g2[7:0]});
        $display("scenario abort: restarted with column0=%0h", g2[7:0]);

        // ---- reset mid-HOLD of column 3 ----
        wait_model(1, 3 * PER + SHIFT_LEN + 2, 200, "hold3_wait");
        l0 = latches.size();
        Reset = 1'b1;
        step();
        chk("reset_mid_hold", {59'd0, SerData, SerClk, Latch, Busy, CharDone}, 64'd0);
        chk("reset_no_latch", latches.size(), l0);
        Reset = 1'b0;
        step();
        chk("recapture_busy", {63'd0, Busy}, 64'd1);
        wait_model(2, -1, 300, "post_reset_done");
        SendData = 1'b0;
        step();
        $display("scenario reset: recaptured and completed");

        // ---- randomized phase ----
        for (int i = 0; i < 4000; i++) begin
            Glyph = GW'({$urandom(), $urandom()});
            if (Reset) Reset = 1'b0;
            else if ($urandom_range(0, 699) == 0) Reset = 1'b1;
            if (SendData) begin
                if ($urandom_range(0, 199) == 0 || (m_mode == 2 && $urandom_range(0, 9) == 0))
                    SendData = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                SendData = 1'b1;
            end
            step();
        end
        $display("scenario random: 4000 cycles");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pov_column_shifter.md
Name: pov_column_shifter

Overview:
- Downstream stage of the POV transmitter controller. Consumes the generated glyph for one character while SendData is high.
- Serialises each column into the external LED shift/latch register pair (SER/SRCLK/RCLK style) and holds each column for a fixed dwell time.
- Signals end-of-character on CharDone, which drives the controller's NullDataChar input.

Parameters:
- LEDS, 8, LEDs per column (bits shifted per column)
- COLS, 5, columns per glyph
- DIV, 2, SerClk half-period in clk cycles (≥1)
- HOLD_CYCLES, 1000, column dwell time in clk cycles after latch (≥1)

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- SendData  in  1  level request from controller; high = emit captured glyph
- Glyph  in  LEDS*COLS  column patterns; column c = Glyph[c*LEDS +: LEDS]
- SerData  out  1  serial data to LED shift register
- SerClk  out  1  shift clock; data valid on rising edge
- Latch  out  1  one-cycle storage-register strobe
- Busy  out  1  high in any state other than IDLE/DONE
- CharDone  out  1  high in DONE; maps to NullDataChar

Behaviour:
- Reset (sampled at clk edge): state IDLE; SerData=0, SerClk=0, Latch=0, Busy=0, CharDone=0; column/bit/divide/hold counters=0; glyph register=0.
- States: IDLE, SHIFT, LATCH, HOLD, DONE.
- IDLE: when SendData=1, capture Glyph into the internal register on that edge; col=0, bit=LEDS-1; go to SHIFT. Glyph changes after capture are ignored until the next IDLE capture.
- SHIFT:
  - Per bit: SerData = glyph[col*LEDS+bit] (MSB first), SerClk=0 for DIV cycles, then SerClk=1 for DIV cycles. That is 2*DIV cycles per bit.
  - After bit 0's high phase, SerClk returns to 0; go to LATCH.
- LATCH: Latch=1 for exactly one cycle, then HOLD.
- HOLD: outputs idle (SerClk=0, Latch=0) for HOLD_CYCLES cycles.
  - If col<COLS-1: col+1, bit=LEDS-1, go to SHIFT.
  - Else: go to DONE.
- DONE: CharDone=1 and held while SendData=1. When SendData=0 is sampled, go to IDLE next edge and CharDone drops.
- Per-column latency: 2*DIV*LEDS + 1 + HOLD_CYCLES cycles. Defaults: 32+1+1000 = 1033.
- Abort: SendData=0 sampled in SHIFT/LATCH/HOLD forces IDLE on that edge.
  - SerClk=0, Latch=0, CharDone stays 0.
  - The partially shifted column is never latched; the LED register keeps its previous column.
- SendData re-asserted in the cycle after abort or DONE→IDLE starts a fresh capture.
- Counters sized to clog2 of their maxima. Col/bit never wrap; the terminal count is checked explicitly.
- Reset mid-operation overrides everything, including a pending Latch.

Optional Feature:
- Macro: POV_GAP_COLUMN_EN.
- Defined: after the last glyph column's HOLD, one extra all-zero column is shifted, latched and held (same timing) before DONE. This gives inter-character spacing; CharDone is delayed by one column period.
- Undefined: DONE follows the last glyph column's HOLD directly, and no blank column is emitted.

Test Plan:
- Parameters for all tests: LEDS=8, COLS=5, DIV=1, HOLD_CYCLES=4 (21 cycles/column).
- Basic bit order: Glyph column0=8'hA5, others 0; raise SendData → SerData at the first 8 SerClk rising edges = 1,0,1,0,0,1,0,1; one Latch pulse after the 8th rise.
- Full character: SendData held high → exactly 5 Latch pulses 21 cycles apart; CharDone rises 105 cycles after the capturing edge. With POV_GAP_COLUMN_EN: 6 pulses, the 6th column shifts 8 zeros, CharDone at 126.
- Handshake: in DONE keep SendData=1 for 10 cycles → CharDone stays 1; drop SendData → CharDone=0 one cycle later; state IDLE, Busy=0.
- Abort: drop SendData during column 2 bit 4 → IDLE next edge, no further SerClk/Latch; re-raise → restarts at column 0 MSB with the newly captured Glyph.
- Reset mid-HOLD of column 3: assert Reset for 1 cycle → all outputs 0 next cycle, no Latch. With SendData held high, capture restarts in the cycle after Reset deasserts.
